// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter. A CPU store to TXDATA queues
//               a byte in a small circular FIFO; a four-state serializer
//               (IDLE/START/DATA/STOP) sends 8N1 frames, LSB first, with
//               every serial bit held for CLK_DIV clocks. Back-to-back
//               frames follow each other with no idle gap.
// Register map: BASE+0 TXDATA (write pushes byte, reads 0)
//               BASE+4 STATUS (bit0 full, bit1 empty, bit2 busy,
//                              bit3 overflow (sticky, any write clears),
//                              bits[8:4] FIFO count)
//               BASE+8 CTRL   (bit0 irq_en, only with MMIO_UART_TX_IRQ_EN)
// Option      : define MMIO_UART_TX_IRQ_EN to add the CTRL register and the
//               irq output. Without it BASE+8 reads 0 and ignores writes.
// Ports       : clock       - single clock, rising edge
//               reset       - synchronous, active-high
//               load        - CPU read strobe
//               store       - CPU write strobe
//               address     - CPU address, bits [1:0] ignored
//               store_data  - CPU write data
//               load_data   - combinational read data, 0 unless a window hit
//               tx          - registered serial output, idle high
//               irq         - (option) registered: irq_en & empty & !busy
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    localparam logic [29:0] WORD_TX = BASE_ADDR[31:2];
    localparam logic [29:0] WORD_ST = BASE_ADDR[31:2] + 30'd1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // ------------------------------------------------------------------------
    // Address decode (word granularity)
    // ------------------------------------------------------------------------
    logic w_hit_tx;
    logic w_hit_st;

    assign w_hit_tx = (address[31:2] == WORD_TX);
    assign w_hit_st = (address[31:2] == WORD_ST);

    // Byte lanes and sub-word address bits that carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^{address[1:0], store_data[31:8]};

    // ------------------------------------------------------------------------
    // TX FIFO: circular buffer, power-of-two depth so pointers wrap naturally
    // ------------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_ovf_event;

    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == DEPTH_C);
    assign w_push_req  = store && w_hit_tx;
    // A pop at the same edge frees a slot, so a full FIFO still accepts.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_event = w_push_req && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= store_data[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky overflow: a new overflow wins over a clear at the same edge
    // ------------------------------------------------------------------------
    logic overflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (w_ovf_event) begin
            overflow_q <= 1'b1;
        end else if (store && w_hit_st) begin
            overflow_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          w_bit_end;

    assign w_bit_end = (timer_q == TIMER_LAST);

    // tx_d is the line level for the state being entered, so the registered
    // tx changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        w_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    state_d   = START;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    state_d   = DATA;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    timer_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    if (!w_empty) begin
                        // Chain straight into the next frame's start bit.
                        w_pop   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------------
    // Status word and read mux
    // ------------------------------------------------------------------------
    logic        w_busy;
    logic [31:0] w_status;

    assign w_busy   = (state_q != IDLE);
    assign w_status = {23'd0, 5'(count_q), overflow_q, w_busy, w_empty, w_full};

`ifdef MMIO_UART_TX_IRQ_EN
    localparam logic [29:0] WORD_CT = BASE_ADDR[31:2] + 30'd2;

    logic w_hit_ct;
    logic irq_en_q;
    logic irq_q;

    assign w_hit_ct = (address[31:2] == WORD_CT);

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (store && w_hit_ct) begin
                irq_en_q <= store_data[0];
            end
            irq_q <= irq_en_q && w_empty && !w_busy;
        end
    end

    assign irq = irq_q;

    always_comb begin
        load_data = '0;
        if (load) begin
            if (w_hit_st) begin
                load_data = w_status;
            end else if (w_hit_ct) begin
                load_data = {31'd0, irq_en_q};
            end
        end
    end
`else
    // TXDATA and all unmapped words read as zero so the bus can OR sources.
    always_comb begin
        load_data = '0;
        if (load && w_hit_st) begin
            load_data = w_status;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx (CLK_DIV=4, depth 4).
//               Table vectors for register access, hand sequences for frame
//               timing, overflow and reset abort, then random traffic checked
//               against a frame-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;
    localparam logic [29:0] W_ST  = 30'(BASE >> 2) + 30'd1;
    localparam logic [29:0] W_TX  = 30'(BASE >> 2);

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic        store;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
    logic        irq;
`endif

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .store     (store),
        .address   (address),
        .store_data(store_data),
        .load_data (load_data),
        .tx        (tx)
`ifdef MMIO_UART_TX_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: pending byte queue plus the age of the frame on air.
    // ------------------------------------------------------------------------
    logic [7:0] mq[$];
    bit         m_active;
    int         m_pos;
    logic [7:0] m_byte;
    bit         m_ovf;

    task automatic model_step();
        bit hit_tx, hit_st, ending;
        if (reset) begin
            mq.delete();
            m_active = 0;
            m_pos    = 0;
            m_ovf    = 0;
        end else begin
            hit_tx = store && (address[31:2] == W_TX);
            hit_st = store && (address[31:2] == W_ST);
            ending = m_active && (m_pos == 10 * DIV - 1);
            if ((!m_active || ending) && mq.size() > 0) begin
                m_byte   = mq.pop_front();
                m_active = 1;
                m_pos    = 0;
            end else if (ending) begin
                m_active = 0;
            end else if (m_active) begin
                m_pos++;
            end
            if (hit_tx && mq.size() >= DEPTH) begin
                m_ovf = 1;
            end else begin
                if (hit_tx) mq.push_back(store_data[7:0]);
                if (hit_st) m_ovf = 0;
            end
        end
    endtask

    function automatic logic m_tx();
        int seg;
        if (!m_active) return 1'b1;
        seg = m_pos / DIV;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return m_byte[seg-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_load();
        logic [4:0] c;
        if (!load || address[31:2] != W_ST) return 32'd0;
        c = 5'(mq.size());
        return {23'd0, c, m_ovf, m_active, (mq.size() == 0), (mq.size() == DEPTH)};
    endfunction

    // ------------------------------------------------------------------------
    // Drive helpers
    // ------------------------------------------------------------------------
    task automatic setin(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
        load       = ld;
        store      = st;
        address    = a;
        store_data = d;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        setin(0, 0, 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // pat[j] is the line level during serial bit slot j (0=start, 9=stop).
    task automatic frame_check(input string name, input logic [9:0] pat, input int first);
        for (int i = first; i < 10 * DIV; i++) begin
            tick();
            chk(name, {31'd0, tx}, {31'd0, pat[i/DIV]});
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_ld;
        logic        exp_tx;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{1'b1, 1'b0, BASE + 32'd4,  32'd0,         32'h0000_0002, 1'b1};
        vt[1]  = '{1'b1, 1'b0, BASE + 32'd12, 32'd0,         32'h0000_0000, 1'b1};
        vt[2]  = '{1'b0, 1'b0, BASE,          32'd0,         32'h0000_0000, 1'b1};
        vt[3]  = '{1'b1, 1'b0, BASE,          32'd0,         32'h0000_0000, 1'b1};
        vt[4]  = '{1'b1, 1'b1, BASE + 32'd8,  32'd1,         32'h0000_0000, 1'b1};
        vt[5]  = '{1'b1, 1'b0, BASE + 32'd8,  32'd0,         32'h0000_0000, 1'b1};
        vt[6]  = '{1'b1, 1'b0, BASE + 32'd7,  32'd0,         32'h0000_0002, 1'b1};
        vt[7]  = '{1'b1, 1'b0, BASE - 32'd4,  32'd0,         32'h0000_0000, 1'b1};
        vt[8]  = '{1'b1, 1'b1, BASE + 32'd4,  32'hFFFF_FFFF, 32'h0000_0002, 1'b1};
        vt[9]  = '{1'b1, 1'b1, BASE + 32'd1,  32'hABCD_125A, 32'h0000_0000, 1'b1};
        vt[10] = '{1'b1, 1'b0, BASE + 32'd4,  32'd0,         32'h0000_0010, 1'b0};
        vt[11] = '{1'b1, 1'b0, BASE + 32'd4,  32'd0,         32'h0000_0006, 1'b0};
        vt[12] = '{1'b0, 1'b0, BASE + 32'd4,  32'd0,         32'h0000_0000, 1'b0};
        vt[13] = '{1'b1, 1'b0, BASE + 32'd4,  32'd0,         32'h0000_0006, 1'b0};

        setin(0, 0, 32'd0, 32'd0);
        reset = 1'b1;

        // ---- reset state ---------------------------------------------------
        do_reset();
        setin(1, 0, BASE + 32'd4, 32'd0);
        #1;
        chk("reset_status", load_data, 32'h0000_0002);
        chk("reset_tx", {31'd0, tx}, 32'd1);

        // ---- register access table -----------------------------------------
        for (int i = 0; i < 14; i++) begin
            setin(vt[i].ld, vt[i].st, vt[i].addr, vt[i].data);
            #1;
            chk($sformatf("vec%0d_ld", i), load_data, vt[i].exp_ld);
            tick();
            chk($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, vt[i].exp_tx});
        end

        // ---- single frame 0x5A ---------------------------------------------
        do_reset();
        setin(0, 1, BASE, 32'h0000_005A);
        tick();
        setin(0, 0, BASE, 32'd0);
        chk("f5A_pre", {31'd0, tx}, 32'd1);
        frame_check("f5A", {1'b1, 8'h5A, 1'b0}, 0);
        setin(1, 0, BASE + 32'd4, 32'd0);
        #1;
        chk("f5A_stop_busy", load_data, 32'h0000_0006);
        tick();
        chk("f5A_idle", load_data, 32'h0000_0002);
        chk("f5A_idle_tx", {31'd0, tx}, 32'd1);

        // ---- back-to-back 0x01, 0x80 ---------------------------------------
        do_reset();
        setin(0, 1, BASE, 32'h0000_0001);
        tick();
        setin(0, 1, BASE, 32'h0000_0080);
        tick();
        setin(0, 0, BASE, 32'd0);
        chk("f01_start", {31'd0, tx}, 32'd0);
        frame_check("f01", {1'b1, 8'h01, 1'b0}, 1);
        frame_check("f80", {1'b1, 8'h80, 1'b0}, 0);
        tick();
        setin(1, 0, BASE + 32'd4, 32'd0);
        #1;
        chk("b2b_idle", load_data, 32'h0000_0002);

        // ---- overflow and full push/pop -------------------------------------
        do_reset();
        for (int s = 0; s < 6; s++) begin
            setin(0, 1, BASE, 32'(s + 1));
            tick();
        end
        setin(1, 0, BASE + 32'd4, 32'd0);
        #1;
        chk("ovf_status", load_data, 32'h0000_004D);
        setin(1, 1, BASE + 32'd4, 32'd0);
        tick();
        setin(1, 0, BASE + 32'd4, 32'd0);
        #1;
        chk("ovf_cleared", load_data, 32'h0000_0045);
        for (int i = 0; i < 34; i++) tick();
        setin(0, 1, BASE, 32'h0000_0077);
        tick();
        setin(1, 0, BASE + 32'd4, 32'd0);
        #1;
        chk("full_pushpop", load_data, 32'h0000_0045);
        chk("full_pushpop_tx", {31'd0, tx}, 32'd0);

        // ---- reset mid-frame -------------------------------------------------
        do_reset();
        setin(0, 1, BASE, 32'h0000_0033);
        tick();
        setin(0, 1, BASE, 32'h0000_0044);
        tick();
        setin(0, 0, BASE, 32'd0);
        for (int i = 0; i < 16; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setin(1, 0, BASE + 32'd4, 32'd0);
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_status", load_data, 32'h0000_0002);
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("abort_quiet", {31'd0, tx}, 32'd1);
        end

        // ---- random traffic against the reference model -------------------
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 4))
                0:       a = BASE;
                1:       a = BASE + 32'd4;
                2:       a = BASE + 32'd8;
                3:       a = BASE + 32'd12;
                default: a = $urandom;
            endcase
            a = a | 32'($urandom_range(0, 3));
            reset = ($urandom_range(0, 499) == 0);
            setin(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, $urandom);
            #1;
            chk("rnd_ld", load_data, m_load());
            tick();
            chk("rnd_tx", {31'd0, tx}, {31'd0, m_tx()});
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: word-aligned base of the register window.
REQ-002 SHALL have parameter CLK_DIV, default 16: clocks per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: TX byte FIFO entries, legal values are powers of two from 2 to 16.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port load, input, 1 bit: CPU data-read strobe.
REQ-007 SHALL have port store, input, 1 bit: CPU data-write strobe.
REQ-008 SHALL have port address, input, 32 bits: CPU data address.
REQ-009 SHALL have port store_data, input, 32 bits: CPU write data.
REQ-010 SHALL have port load_data, output, 32 bits: read data, combinational, valid in the same cycle as load.
REQ-011 SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-012 SHALL decode address[31:2] only; address[1:0] ignored.
- Register map:
  - BASE+0 TXDATA
  - BASE+4 STATUS
  - BASE+8 CTRL (only when the macro in REQ-027 is defined)
REQ-013 SHALL drive load_data to 0 whenever load=0 or the address misses the window, so the top level can OR it with other sources.
REQ-014 SHALL return 0 on a TXDATA read.
REQ-015 SHALL return STATUS on a STATUS read:
- bit0 full
- bit1 empty
- bit2 busy (state != IDLE)
- bit3 overflow (sticky)
- bits[8:4] FIFO count
- all other bits 0
REQ-016 SHALL handle a store to TXDATA by pushing store_data[7:0] at that clock edge; bits [31:8] are ignored.
REQ-017 SHALL drop a push when the FIFO is full and no pop occurs at the same edge, and SHALL set overflow at that edge; a push and a pop at the same edge on a full FIFO SHALL be accepted, leaving count unchanged.
REQ-018 SHALL clear overflow on any store to STATUS, regardless of data; a clear and an overflow event at the same edge SHALL leave overflow set.
REQ-019 SHALL implement the FIFO as a circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-020 SHALL implement the state machine IDLE -> START -> DATA -> STOP, with these transitions:
- IDLE: when the FIFO is not empty, pop the head into the shift register at the next edge and enter START.
- START: tx=0 for CLK_DIV clocks, then enter DATA.
- DATA: 8 bits, LSB first, each bit held for CLK_DIV clocks, then enter STOP.
- STOP: tx=1 for CLK_DIV clocks; then, if the FIFO is not empty, pop and enter START at that same edge with no idle gap; otherwise enter IDLE.
REQ-021 SHALL register tx; tx SHALL be 1 in IDLE and STOP.
REQ-022 SHALL meet the following latency:
- A push into an empty FIFO in IDLE at edge k causes a pop at edge k+1, and tx falls after edge k+1.
- One frame lasts exactly 10*CLK_DIV clocks.
REQ-023 SHALL use a bit-timer counter of width clog2(CLK_DIV) and a 3-bit data-bit counter; both reload at every state entry.

Reset
REQ-024 SHALL, at a clock edge with reset=1, empty the FIFO (pointers and count 0), enter IDLE, set tx=1, clear overflow, and clear all counters and the shift register; reset SHALL take priority over any store at the same edge.
REQ-025 SHALL, when reset is asserted mid-frame, abort the frame: tx=1 from the following cycle, and the in-flight byte and queued bytes are lost.
REQ-026 SHALL drive load_data to 0 whenever load=0, including during reset.

Configuration
REQ-027 SHALL, when macro MMIO_UART_TX_IRQ_EN is defined, add port irq (output, 1 bit) and CTRL register bit0 irq_en (read/write, reset 0); irq SHALL be registered and equal to irq_en AND empty AND NOT busy.
REQ-028 SHALL, when MMIO_UART_TX_IRQ_EN is undefined, omit the irq port and the CTRL register; BASE+8 SHALL then read 0 and ignore writes.

Verification
REQ-029 SHALL cover: CLK_DIV=4; store 0x5A to TXDATA -> tx low after the next edge for 4 clocks, then bits 0,1,0,1,1,0,1,0 at 4 clocks each, then high for 4 clocks; busy=0 after 40 clocks.
REQ-030 SHALL cover: stores of 0x01 then 0x80 on consecutive cycles -> two frames back-to-back with no idle gap, 80 clocks total.
REQ-031 SHALL cover: FIFO_DEPTH=4, five stores while the first frame is still starting -> the fifth accepted only if a pop coincides, otherwise STATUS shows full=1 and overflow=1; a store to STATUS then reads overflow=0.
REQ-032 SHALL cover: load from STATUS while idle -> 0x0000_0002; load from BASE+12 and load=0 with address=BASE -> load_data=0.
REQ-033 SHALL cover: reset asserted 17 clocks into a frame -> tx=1, STATUS=0x0000_0002 on the next cycle, and no further frame is sent.
REQ-034 SHALL cover, with MMIO_UART_TX_IRQ_EN defined: write CTRL=1 while idle -> irq=1 one clock later; push a byte -> irq=0 until the frame ends.
